fb_scanout: RTL and testbench

//  Framebuffer sink for gpu write port (fb_x/fb_y/fb_color/fb_write) plus display scanout.

---
 rtl/fb_scanout_if.sv | 28 ++
 rtl/fb_scanout.sv | 185 ++++++++++++++++++
 tb/tb_fb_scanout.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_if.sv
// Signal bundle between a GPU/controller (master) and the fb_scanout framebuffer (slave).
// Covers the pixel write port, clear/swap control, status flags and the video stream.
interface fb_scanout_if;
    logic [7:0]  fb_x;
    logic [7:0]  fb_y;
    logic [15:0] fb_color;
    logic        fb_write;
    logic        clear_req;
    logic [15:0] clear_color;
    logic        swap_req;
    logic        busy;
    logic        swap_pending;
    logic        swap_done;
    logic        vid_hsync;
    logic        vid_vsync;
    logic        vid_de;
    logic [15:0] vid_color;

    modport master (
        output fb_x, fb_y, fb_color, fb_write, clear_req, clear_color, swap_req,
        input  busy, swap_pending, swap_done, vid_hsync, vid_vsync, vid_de, vid_color
    );

    modport slave (
        input  fb_x, fb_y, fb_color, fb_write, clear_req, clear_color, swap_req,
        output busy, swap_pending, swap_done, vid_hsync, vid_vsync, vid_de, vid_color
    );
endinterface

// File: rtl/fb_scanout.sv
// Double-buffered RGB565 framebuffer with raster scanout, clear engine and vblank buffer swap.
// state   | meaning
// S_IDLE  | no clear running, GPU writes accepted
// S_CLEAR | filling back buffer with latched colour, one pixel per clk
module fb_scanout #(
    parameter int H_ACTIVE = 240,
    parameter int V_ACTIVE = 160,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BACK   = 48,
    parameter int V_FRONT  = 3,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 6,
    parameter int PIX_DIV  = 4
) (
    input logic          clk,
    input logic          rstn,
    fb_scanout_if.slave  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int N       = H_ACTIVE * V_ACTIVE;
    localparam int PAW     = (N > 1) ? $clog2(N) : 1;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;

    logic [15:0] mem [0:1][0:N-1];

    logic [DW-1:0]  div_q, div_d;
    logic [9:0]     h_q, h_d, v_q, v_d;
    logic           front_q, front_d, pend_q, pend_d, done_q, done_d;
    clr_state_t     state_q, state_d;
    logic [PAW-1:0] clr_addr_q, clr_addr_d;
    logic [15:0]    clr_color_q, clr_color_d;
    logic           tick1_q, tick1_d;
    logic           p_de_q, p_de_d, p_hs_q, p_hs_d, p_vs_q, p_vs_d;
    logic           de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [15:0]    color_q, color_d;
    logic [15:0]    rd_data_q;

    logic           tick, active, hs_n, vs_n, swap_pt, want_swap;
    logic           busy, clr_we, fb_ok, wr_en, back_buf;
    logic [PAW-1:0] rd_addr, wr_addr;
    logic [15:0]    wr_data;

    always_comb begin
        tick  = (div_q == DW'(PIX_DIV - 1));
        div_d = tick ? '0 : div_q + DW'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == 10'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        active  = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
        hs_n    = !((h_q >= 10'(H_ACTIVE + H_FRONT)) && (h_q < 10'(H_ACTIVE + H_FRONT + H_SYNC)));
        vs_n    = !((v_q >= 10'(V_ACTIVE + V_FRONT)) && (v_q < 10'(V_ACTIVE + V_FRONT + V_SYNC)));
        rd_addr = PAW'(32'(v_q) * H_ACTIVE + 32'(h_q));
    end

    // Stage 1 captures sync/de alongside the RAM read; stage 2 presents both together.
    always_comb begin
        tick1_d = tick;
        p_de_d  = p_de_q;
        p_hs_d  = p_hs_q;
        p_vs_d  = p_vs_q;
        if (tick) begin
            p_de_d = active;
            p_hs_d = hs_n;
            p_vs_d = vs_n;
        end
        de_d    = de_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        color_d = color_q;
        if (tick1_q) begin
            de_d    = p_de_q;
            hs_d    = p_hs_q;
            vs_d    = p_vs_q;
            color_d = p_de_q ? rd_data_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.clear_req) state_d = S_CLEAR;
            S_CLEAR: if (clr_addr_q == PAW'(N - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == S_CLEAR);
        clr_we      = busy;
        clr_addr_d  = busy ? clr_addr_q + PAW'(1) : '0;
        clr_color_d = (!busy && bus.clear_req) ? bus.clear_color : clr_color_q;
    end

    always_comb begin
        fb_ok    = bus.fb_write && ({2'b00, bus.fb_x} < 10'(H_ACTIVE)) && ({2'b00, bus.fb_y} < 10'(V_ACTIVE));
        wr_en    = clr_we || (fb_ok && !busy);
        wr_addr  = clr_we ? clr_addr_q : PAW'(32'(bus.fb_y) * H_ACTIVE + 32'(bus.fb_x));
        wr_data  = clr_we ? clr_color_q : bus.fb_color;
        back_buf = ~front_q;
    end

    // A swap_req arriving in the swap-point cycle still takes effect at that swap point.
    always_comb begin
        swap_pt   = tick && (h_q == 10'd0) && (v_q == 10'(V_ACTIVE));
        want_swap = pend_q || bus.swap_req;
        front_d   = front_q;
        pend_d    = want_swap;
        done_d    = 1'b0;
        if (swap_pt && want_swap && !busy) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            front_q     <= 1'b0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
            tick1_q     <= 1'b0;
            p_de_q      <= 1'b0;
            p_hs_q      <= 1'b1;
            p_vs_q      <= 1'b1;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            color_q     <= '0;
        end else begin
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            front_q     <= front_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
            tick1_q     <= tick1_d;
            p_de_q      <= p_de_d;
            p_hs_q      <= p_hs_d;
            p_vs_q      <= p_vs_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            color_q     <= color_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[back_buf][wr_addr] <= wr_data;
        if (tick && active) rd_data_q <= mem[front_q][rd_addr];
    end

    assign bus.busy         = busy;
    assign bus.swap_pending = pend_q;
    assign bus.swap_done    = done_q;
    assign bus.vid_hsync    = hs_q;
    assign bus.vid_vsync    = vs_q;
    assign bus.vid_de       = de_q;
    assign bus.vid_color    = color_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a 4x3 frame with unit porches and one clk per pixel.
module tb_fb_scanout;
    localparam int HA = 4, VA = 3, HF = 1, HS = 1, HB = 1, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int NPIX = HA * VA;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] color;
        int          exp_pix;
    } wr_vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc;
    int   errors = 0;
    int   checks = 0;

    fb_scanout_if bus ();

    fb_scanout #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIX_DIV(1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Clocks since reset release; equals the DUT scan position modulo FT.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sync_to(input int phase);
        int n = 0;
        while ((cyc % FT) != phase && n < FT + 2) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_clear(input logic [15:0] c);
        bus.clear_req   = 1'b1;
        bus.clear_color = c;
        @(negedge clk);
        bus.clear_req   = 1'b0;
    endtask

    task automatic pulse_swap();
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
    endtask

    task automatic write_px(input logic [7:0] x, input logic [7:0] y, input logic [15:0] c);
        bus.fb_x     = x;
        bus.fb_y     = y;
        bus.fb_color = c;
        bus.fb_write = 1'b1;
        @(negedge clk);
        bus.fb_write = 1'b0;
    endtask

    task automatic wait_busy_low();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_swap_done(output int t);
        int n = 0;
        while (!bus.swap_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.swap_done) chk("swap_done_timeout", 32'(bus.swap_done), 32'd1);
        t = cyc;
    endtask

    // Walks one full frame of video output, comparing every pixel slot against the raster model.
    task automatic check_frame(input logic [15:0] exp [NPIX], input bit chk_col, input string tag,
                               output int de_cnt);
        int p, h, v;
        bit ede, ehs, evs;
        de_cnt = 0;
        while ((cyc % FT) != 2) @(negedge clk);
        for (int i = 0; i < FT; i++) begin
            p   = (cyc - 2) % FT;
            h   = p % HT;
            v   = p / HT;
            ede = (h < HA) && (v < VA);
            ehs = !(h == HA + HF);
            evs = !(v == VA + VF);
            chk($sformatf("%s_de_p%0d", tag, p), 32'(bus.vid_de), 32'(ede));
            chk($sformatf("%s_hs_p%0d", tag, p), 32'(bus.vid_hsync), 32'(ehs));
            chk($sformatf("%s_vs_p%0d", tag, p), 32'(bus.vid_vsync), 32'(evs));
            if (!ede)         chk($sformatf("%s_blank_p%0d", tag, p), 32'(bus.vid_color), 32'd0);
            else if (chk_col) chk($sformatf("%s_px_%0d_%0d", tag, h, v), 32'(bus.vid_color), 32'(exp[v * HA + h]));
            if (bus.vid_de) de_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        wr_vec_t     vecs [9];
        logic [15:0] model [NPIX];
        logic [15:0] fill  [NPIX];
        int t, n, base, dec;

        vecs[0] = '{x: 8'd1,   y: 8'd2,   color: 16'hF800, exp_pix: 9};
        vecs[1] = '{x: 8'd4,   y: 8'd0,   color: 16'hFFFF, exp_pix: -1};
        vecs[2] = '{x: 8'd0,   y: 8'd3,   color: 16'hFFFF, exp_pix: -1};
        vecs[3] = '{x: 8'd3,   y: 8'd0,   color: 16'h001F, exp_pix: 3};
        vecs[4] = '{x: 8'd0,   y: 8'd0,   color: 16'hABCD, exp_pix: 0};
        vecs[5] = '{x: 8'd3,   y: 8'd2,   color: 16'h1234, exp_pix: 11};
        vecs[6] = '{x: 8'd255, y: 8'd255, color: 16'hBEEF, exp_pix: -1};
        vecs[7] = '{x: 8'd2,   y: 8'd1,   color: 16'h5A5A, exp_pix: 6};
        vecs[8] = '{x: 8'd2,   y: 8'd1,   color: 16'h0F0F, exp_pix: 6};

        bus.fb_x = '0; bus.fb_y = '0; bus.fb_color = '0; bus.fb_write = 1'b0;
        bus.clear_req = 1'b0; bus.clear_color = '0; bus.swap_req = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_hsync", 32'(bus.vid_hsync), 32'd1);
        chk("rst_vsync", 32'(bus.vid_vsync), 32'd1);
        chk("rst_de", 32'(bus.vid_de), 32'd0);
        chk("rst_color", 32'(bus.vid_color), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pending", 32'(bus.swap_pending), 32'd0);
        chk("rst_done", 32'(bus.swap_done), 32'd0);
        rstn = 1'b1;

        // Raster timing over a full frame.
        for (int i = 0; i < NPIX; i++) fill[i] = '0;
        check_frame(fill, 1'b0, "tim", dec);
        chk("de_count", 32'(dec), 32'(NPIX));

        // Clear buf1 to green with a write attempted mid-clear, then swap it to front.
        sync_to(30);
        pulse_clear(16'h07E0);
        bus.fb_x = 8'd0; bus.fb_y = 8'd0; bus.fb_color = 16'h1234;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            bus.fb_write = (n == 3);
            @(negedge clk);
        end
        bus.fb_write = 1'b0;
        chk("busy_len", 32'(n), 32'(NPIX));
        pulse_swap();
        chk("pend_set", 32'(bus.swap_pending), 32'd1);
        wait_swap_done(t);
        chk("swap_phase", 32'(t % FT), 32'(FT / VT * VA + 1));
        @(negedge clk);
        chk("done_pulse", 32'(bus.swap_done), 32'd0);
        chk("pend_clr", 32'(bus.swap_pending), 32'd0);
        for (int i = 0; i < NPIX; i++) fill[i] = 16'h07E0;
        check_frame(fill, 1'b1, "clr", dec);

        // Zero buf0, apply the write table, swap and read it back.
        pulse_clear(16'h0000);
        wait_busy_low();
        for (int i = 0; i < NPIX; i++) model[i] = '0;
        for (int i = 0; i < 9; i++) begin
            write_px(vecs[i].x, vecs[i].y, vecs[i].color);
            if (vecs[i].exp_pix >= 0) model[vecs[i].exp_pix] = vecs[i].color;
        end
        sync_to(30);
        pulse_swap();
        wait_swap_done(t);
        chk("swap_phase2", 32'(t % FT), 32'(HT * VA + 1));
        check_frame(model, 1'b1, "wr", dec);

        // Clear spanning the swap point defers the swap to the following frame.
        sync_to(15);
        base = cyc - 15;
        pulse_clear(16'h001F);
        pulse_swap();
        while (cyc < base + 30) @(negedge clk);
        chk("defer_pend", 32'(bus.swap_pending), 32'd1);
        wait_swap_done(t);
        chk("defer_at", 32'(t - base), 32'(FT + HT * VA + 1));
        for (int i = 0; i < NPIX; i++) fill[i] = 16'h001F;
        check_frame(fill, 1'b1, "defer", dec);

        // Reset mid-line and mid-clear: pixels 0..3 of buf0 were cleared before the abort.
        sync_to(5);
        pulse_clear(16'h7777);
        pulse_swap();
        sync_to(10);
        chk("pre_rst_de", 32'(bus.vid_de), 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_hsync", 32'(bus.vid_hsync), 32'd1);
        chk("arst_vsync", 32'(bus.vid_vsync), 32'd1);
        chk("arst_de", 32'(bus.vid_de), 32'd0);
        chk("arst_color", 32'(bus.vid_color), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_pending", 32'(bus.swap_pending), 32'd0);
        chk("arst_done", 32'(bus.swap_done), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("restart_pipe_de", 32'(bus.vid_de), 32'd0);
        for (int i = 0; i < 4; i++) model[i] = 16'h7777;
        check_frame(model, 1'b1, "rst", dec);

        // swap_req landing exactly in the swap-point cycle is honoured immediately.
        sync_to(HT * VA);
        pulse_swap();
        chk("swap_at_pt", 32'(bus.swap_done), 32'd1);
        chk("swap_at_pt_pend", 32'(bus.swap_pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
